// File: rtl/alu_io_pkg.sv
// Shared types and layout constants for the dual 4-bit ALU pin responder.
package alu_io_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    // pin_in layout: {sel2, sel1, b1, a1, b0, a0}
    localparam int PIN_IN_W        = 20;
    localparam int PIN_LANE_STRIDE = 8;   // a1/b1 sit 8 bits above a0/b0
    localparam int PIN_A_OFS       = 0;
    localparam int PIN_B_OFS       = 4;
    localparam int PIN_SEL_LSB     = 16;  // sel1 at [17:16], sel2 at [19:18]
    localparam int NUM_LANES       = 2;

    // pin_out layout: {res1[4:0], res0[4:0], zero1, zero0, valid, toggle, alive}
    localparam int PIN_OUT_W       = 15;
    localparam int OUT_RES1_LSB    = 10;
    localparam int OUT_RES0_LSB    = 5;
    localparam int OUT_ZERO1_BIT   = 4;
    localparam int OUT_ZERO0_BIT   = 3;
    localparam int OUT_VALID_BIT   = 2;
    localparam int OUT_TOGGLE_BIT  = 1;
    localparam int OUT_ALIVE_BIT   = 0;
    localparam int OUT_DATA_W      = PIN_OUT_W - OUT_ZERO0_BIT;  // bits [14:3]

endpackage

// File: rtl/alu4_lane.sv
// One 4-bit ALU lane: add/sub with carry/borrow in bit 4, and/or, plus zero flag.
module alu4_lane
    import alu_io_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] sel,
    output logic [4:0] res,
    output logic       zero
);

    // Select the operation; zero looks only at the low nibble.
    always_comb begin
        res = 5'd0;
        case (sel)
            OP_ADD:  res = {1'b0, a} + {1'b0, b};
            OP_SUB:  res = {1'b0, a} - {1'b0, b};
            OP_AND:  res = {1'b0, a & b};
            default: res = {1'b0, a | b};
        endcase
        zero = (res[3:0] == 4'd0);
    end

endmodule

// File: rtl/alu_io_responder.sv
// Pin-side responder: synchronize and debounce the 20 operand pins, commit a
// stable word, and present both ALU lane results registered on 15 output pins.
module alu_io_responder
    import alu_io_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                 clock,
    input  logic                 resetb,
    input  logic [PIN_IN_W-1:0]  pin_in,
    output logic [PIN_OUT_W-1:0] pin_out,
    output logic [PIN_OUT_W-1:0] pin_oeb,
    output logic                 commit_pulse
);

    localparam logic [CNT_W-1:0] STABLE_LIMIT = CNT_W'(STABLE_CYCLES);

    logic [PIN_IN_W-1:0]   sync1_reg;
    logic [PIN_IN_W-1:0]   sync2_reg;
    logic [PIN_IN_W-1:0]   candidate_reg;
    logic [PIN_IN_W-1:0]   candidate_next;
    logic [PIN_IN_W-1:0]   accepted_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [CNT_W-1:0]      count_next;
    state_t                state_reg;
    state_t                state_next;
    logic                  commit_en;

    logic [4:0]            lane_res  [NUM_LANES];
    logic                  lane_zero [NUM_LANES];

    logic [OUT_DATA_W-1:0] result_reg;
    logic                  valid_reg;
    logic                  toggle_reg;
    logic                  alive_reg;
    logic                  commit_pulse_reg;

    // The lanes always evaluate the candidate, so the result is ready in COMMIT.
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            alu4_lane u_lane (
                .a    (candidate_reg[gi*PIN_LANE_STRIDE + PIN_A_OFS +: 4]),
                .b    (candidate_reg[gi*PIN_LANE_STRIDE + PIN_B_OFS +: 4]),
                .sel  (candidate_reg[PIN_SEL_LSB + 2*gi +: 2]),
                .res  (lane_res[gi]),
                .zero (lane_zero[gi])
            );
        end
    endgenerate

    // Two-flop synchronizer on every input pin.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= pin_in;
            sync2_reg <= sync1_reg;
        end
    end

    // Debounce FSM state, candidate word, settle counter and accepted word.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_reg     <= IDLE;
            candidate_reg <= '0;
            count_reg     <= '0;
            accepted_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            candidate_reg <= candidate_next;
            count_reg     <= count_next;
            if (commit_en) begin
                accepted_reg <= candidate_reg;
            end
        end
    end

    // Next state: any glitch restarts the count; a full stable run commits.
    always_comb begin
        state_next     = state_reg;
        candidate_next = candidate_reg;
        count_next     = count_reg;
        commit_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sync2_reg != accepted_reg) begin
                    candidate_next = sync2_reg;
                    count_next     = CNT_W'(1);
                    state_next     = (STABLE_CYCLES == 1) ? COMMIT : SETTLE;
                end
            end
            SETTLE: begin
                if (sync2_reg != candidate_reg) begin
                    candidate_next = sync2_reg;
                    count_next     = CNT_W'(1);
                end else begin
                    count_next = count_reg + CNT_W'(1);
                end
                if (count_next == STABLE_LIMIT) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                commit_en  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output register: results, valid and toggle change only on a commit.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            result_reg       <= '0;
            valid_reg        <= 1'b0;
            toggle_reg       <= 1'b0;
            alive_reg        <= 1'b0;
            commit_pulse_reg <= 1'b0;
        end else begin
            alive_reg        <= 1'b1;
            commit_pulse_reg <= commit_en;
            if (commit_en) begin
                result_reg <= {lane_res[1], lane_res[0], lane_zero[1], lane_zero[0]};
                valid_reg  <= 1'b1;
                toggle_reg <= ~toggle_reg;
            end
        end
    end

    assign pin_out      = {result_reg, valid_reg, toggle_reg, alive_reg};
    assign pin_oeb      = '0;
    assign commit_pulse = commit_pulse_reg;

endmodule

// File: tb/tb_alu_io_responder.sv
// Randomized and directed bench for alu_io_responder against a history-based model.
module tb_alu_io_responder;

    localparam int STABLE = 4;

    logic        clock  = 1'b0;
    logic        resetb = 1'b1;
    logic [19:0] pin_in = '0;
    logic [14:0] pin_out;
    logic [14:0] pin_oeb;
    logic        commit_pulse;

    int errors  = 0;
    int checks  = 0;
    int commits = 0;

    alu_io_responder #(
        .STABLE_CYCLES (STABLE),
        .CNT_W         (8)
    ) dut (
        .clock        (clock),
        .resetb       (resetb),
        .pin_in       (pin_in),
        .pin_out      (pin_out),
        .pin_oeb      (pin_oeb),
        .commit_pulse (commit_pulse)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference ALU from the opcode table, using plain integer arithmetic.
    function automatic int lane_ref(input int a, input int b, input int s);
        case (s)
            0:       return a + b;
            1:       return (a - b + 32) % 32;
            2:       return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [11:0] fields_ref(input logic [19:0] w);
        int r0;
        int r1;
        logic [11:0] f;
        r0 = lane_ref(int'(w[3:0]),  int'(w[7:4]),   int'(w[17:16]));
        r1 = lane_ref(int'(w[11:8]), int'(w[15:12]), int'(w[19:18]));
        f = {r1[4:0], r0[4:0], (r1 % 16) == 0, (r0 % 16) == 0};
        return f;
    endfunction

    // Model state: sync pipeline, history of samples since arming, output image.
    logic [19:0] m_s1 = '0, m_s2 = '0, m_acc = '0, m_commit_word = '0;
    logic [19:0] hist[$];
    logic        armed = 1'b0, commit_due = 1'b0;
    logic [11:0] m_fields = '0;
    logic        m_valid = 1'b0, m_toggle = 1'b0, m_alive = 1'b0, m_pulse = 1'b0;

    // Commit decision: a sample run of STABLE identical values since arming.
    task automatic model_judge(input logic [19:0] s);
        int run;
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == s) run++;
            else break;
        end
        if (run >= STABLE) begin
            commit_due    = 1'b1;
            m_commit_word = s;
            armed         = 1'b0;
            hist.delete();
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or negedge resetb);
            if (!resetb) begin
                m_s1 = '0; m_s2 = '0; m_acc = '0; hist.delete();
                armed = 0; commit_due = 0; m_fields = '0;
                m_valid = 0; m_toggle = 0; m_alive = 0; m_pulse = 0;
            end else begin
                m_pulse = 1'b0;
                if (commit_due) begin
                    m_acc      = m_commit_word;
                    m_fields   = fields_ref(m_commit_word);
                    m_valid    = 1'b1;
                    m_toggle   = ~m_toggle;
                    m_pulse    = 1'b1;
                    commit_due = 1'b0;
                end else if (!armed) begin
                    if (m_s2 != m_acc) begin
                        armed = 1'b1;
                        hist.push_back(m_s2);
                        model_judge(m_s2);
                    end
                end else begin
                    hist.push_back(m_s2);
                    model_judge(m_s2);
                end
                m_alive = 1'b1;
                m_s2    = m_s1;
                m_s1    = pin_in;
            end
        end
    end

    // Cycle-by-cycle comparison on the falling edge, one line per commit.
    always @(negedge clock) begin
        check("pin_out", 32'(pin_out), 32'({m_fields, m_valid, m_toggle, m_alive}));
        check("commit_pulse", 32'(commit_pulse), 32'(m_pulse));
        if (commit_pulse) begin
            commits++;
            $display("commit %0d: pin_out=%04h at %0t", commits, pin_out, $time);
        end
    end

    task automatic drive(input logic [19:0] v);
        @(posedge clock);
        #1 pin_in = v;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
    endtask

    initial begin
        int n;
        int c0;
        logic [19:0] base;
        logic [11:0] saved;

        #2 resetb = 1'b0;
        wait_cycles(3);
        #3 resetb = 1'b1;
        check("pin_oeb", 32'(pin_oeb), 32'h0);
        wait_cycles(3);

        // First commit: latency from pin change and exact result word.
        drive(20'h00099);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock);
            #1;
            if (commit_pulse) begin
                n = i;
                break;
            end
        end
        check("latency", 32'(n), 32'd7);
        check("first_out", 32'(pin_out), 32'(15'b00000_10010_10111));
        @(posedge clock);
        #1 check("pulse_width", 32'(commit_pulse), 32'd0);
        wait_cycles(5);

        // Subtract with borrow on lane 0; toggle returns to 0.
        drive(20'h10053);
        wait_cycles(12);
        check("sub_res0", 32'(pin_out[9:5]), 32'h1E);
        check("toggle_back", 32'(pin_out[1]), 32'd0);

        // AND then OR on lane 1, two separate commits.
        c0 = commits;
        drive(20'h8AC53);
        wait_cycles(12);
        check("and_res1", 32'(pin_out[14:10]), 32'h08);
        drive(20'hCAC53);
        wait_cycles(12);
        check("or_res1", 32'(pin_out[14:10]), 32'h0E);
        check("two_commits", 32'(commits - c0), 32'd2);

        // Short glitch: result fields must not move.
        base  = 20'hCAC53;
        saved = pin_out[14:3];
        drive(base ^ 20'h1);
        wait_cycles(1);
        drive(base);
        wait_cycles(12);
        check("glitch2_fields", 32'(pin_out[14:3]), 32'(saved));

        // Long glitch: commit of the flipped word, then of the restored word.
        c0 = commits;
        drive(base ^ 20'h1);
        wait_cycles(5);
        drive(base);
        wait_cycles(14);
        check("glitch6_commits", 32'(commits - c0), 32'd2);

        // Toggling every 3 cycles never settles; one commit after it stops.
        c0 = commits;
        for (int i = 0; i < 34; i++) begin
            base = base ^ 20'h20;
            drive(base);
            wait_cycles(2);
        end
        check("toggle_none", 32'(commits - c0), 32'd0);
        wait_cycles(12);
        check("toggle_final", 32'(commits - c0), 32'd1);
        check("toggle_fields", 32'(pin_out[14:3]), 32'(fields_ref(base)));

        // Reset during SETTLE clears outputs at once; same input recommits.
        drive(20'h34567);
        wait_cycles(3);
        #3 resetb = 1'b0;
        #1 check("async_reset", 32'(pin_out), 32'h0);
        wait_cycles(2);
        #3 resetb = 1'b1;
        c0 = commits;
        wait_cycles(14);
        check("reset_recommit", 32'(commits - c0), 32'd1);
        check("reset_valid", 32'(pin_out[2]), 32'd1);
        check("reset_fields", 32'(pin_out[14:3]), 32'(fields_ref(20'h34567)));

        // Random words held for random durations, checked every cycle.
        for (int i = 0; i < 40; i++) begin
            drive(20'($urandom));
            wait_cycles($urandom_range(0, 7));
        end
        wait_cycles(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
